// File: rtl/sram_1rw_pipe.sv
// Single-port SRAM with a pipelined read path and an in-order response FIFO.
// Define SRAM_PARITY_EN to store and check one even-parity bit per byte.
module sram_1rw_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(READ_LATENCY);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(READ_LATENCY - 1);

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             wr_acc;
    logic             rd_acc;
    logic             rsp_hs;

    assign req_ready_o = (cnt < CNT_MAX) && !rst;
    assign accept      = req_valid_i && req_ready_o;
    assign wr_acc      = accept && req_we_i;
    assign rd_acc      = accept && !req_we_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            unique case ({rd_acc, rsp_hs})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  rd_err;

    // NOTE: the array has no reset branch on purpose; contents survive rst
    // and a reset port here would prevent mapping onto an SRAM macro.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int k = 0; k < NB; k++) begin
                if (req_be_i[k]) mem[req_addr_i][8*k +: 8] <= req_wdata_i[8*k +: 8];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        logic [NB-1:0] p;
        for (int k = 0; k < NB; k++) p[k] = ^d[8*k +: 8];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int k = 0; k < NB; k++) begin
                if (req_be_i[k]) par_mem[req_addr_i][k] <= ^req_wdata_i[8*k +: 8];
            end
        end
    end

    assign rd_err = |(byte_parity(mem[req_addr_i]) ^ par_mem[req_addr_i]);
`else
    assign rd_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read pipeline: memory sampled at the accept edge into stage 0
    // ------------------------------------------------------------------
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_err;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            pipe_data[0] <= mem[req_addr_i];
            pipe_err[0]  <= rd_err;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_err[i]  <= pipe_err[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO with bypass from the last stage when empty
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fifo_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] fifo_err;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  fifo_empty;
    logic                  last_valid;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_err;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign last_valid = pipe_valid[READ_LATENCY-1];
    assign fifo_empty = (fifo_cnt == '0);
    assign out_valid  = !rst && (!fifo_empty || last_valid);
    assign out_data   = fifo_empty ? pipe_data[READ_LATENCY-1] : fifo_data[rd_ptr];
    assign out_err    = fifo_empty ? pipe_err[READ_LATENCY-1]  : fifo_err[rd_ptr];
    assign rsp_hs     = out_valid && rsp_ready_i;

    // A bypassed response taken in the same cycle never lands in the FIFO.
    assign push = last_valid && !(fifo_empty && rsp_ready_i);
    assign pop  = rsp_hs && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_data[wr_ptr] <= pipe_data[READ_LATENCY-1];
            fifo_err[wr_ptr]  <= pipe_err[READ_LATENCY-1];
        end
    end

    assign rsp_valid_o = out_valid;
    assign rsp_rdata_o = out_valid ? out_data : '0;
    assign rsp_err_o   = out_valid && out_err;

    // ------------------------------------------------------------------
    // Occupancy invariants
    // ------------------------------------------------------------------
    a_cnt_bound : assert property (@(posedge clk) disable iff (rst) cnt <= CNT_MAX);
    a_fifo_le_cnt : assert property (@(posedge clk) disable iff (rst) fifo_cnt <= cnt);
    a_empty_idle : assert property (@(posedge clk) disable iff (rst) (cnt == '0) |-> !rsp_valid_o);

endmodule

// File: tb/tb_sram_1rw_pipe.sv
// Self-checking bench for sram_1rw_pipe: directed scenarios plus a randomized
// run checked against a transaction-level model (word array + response queue).
module tb_sram_1rw_pipe;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [3:0]  req_be_i;
    logic [13:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int checks   = 0;
    int failures = 0;

    sram_1rw_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .READ_LATENCY(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_be_i    (req_be_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk = ~clk;

    // Reference storage: whole words, byte-merged by plain arithmetic.
    logic [31:0] model_mem [int];

    typedef struct {
        logic [31:0] data;
        int          t_acc;
    } rsp_t;

    rsp_t exp_q[$];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = old_w;
        for (int k = 0; k < 4; k++) if (be[k]) m[8*k +: 8] = new_w[8*k +: 8];
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_be_i    = 4'h0;
        req_addr_i  = '0;
        req_wdata_i = '0;
    endtask

    task automatic do_write(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] be);
        int n;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_be_i    = be;
        req_addr_i  = addr;
        req_wdata_i = data;
        #1;
        n = 0;
        while (!req_ready_o && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n == 20) begin
            failures++;
            $display("FAIL write_timeout addr=%h got ready=%b want 1", addr, req_ready_o);
        end
        tick();
        idle_inputs();
        if (model_mem.exists(int'(addr))) model_mem[int'(addr)] = merge(model_mem[int'(addr)], data, be);
        else model_mem[int'(addr)] = merge(32'h0, data, be);
    endtask

    task automatic do_read(input logic [13:0] addr, output logic [31:0] data, output logic err,
                           output int lat);
        int n;
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = addr;
        #1;
        n = 0;
        while (!req_ready_o && n < 20) begin
            tick();
            n++;
        end
        tick();
        idle_inputs();
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        data = rsp_rdata_o;
        err  = rsp_err_o;
        checks++;
        if (n == 20 || lat == 20) begin
            failures++;
            $display("FAIL read_timeout addr=%h got valid=%b want 1", addr, rsp_valid_o);
        end
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rsp_ready_i = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o} !== 3'b000 || rsp_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b err=%b rdata=%h want 0 0 0 0",
                     req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%b valid=%b want 1 0", req_ready_o, rsp_valid_o);
        end
        tick();
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        logic        e;
        int          lat;
        do_write(14'h0010, 32'hDEADBEEF, 4'hF);
        do_read(14'h0010, d, e, lat);
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0 || lat != L) begin
            failures++;
            $display("FAIL write_read got data=%h err=%b lat=%0d want DEADBEEF 0 %0d", d, e, lat, L);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] d;
        logic        e;
        int          lat;
        do_write(14'h0010, 32'h11223344, 4'h5);
        do_read(14'h0010, d, e, lat);
        checks++;
        if (d !== 32'hDE22BE44 || e !== 1'b0) begin
            failures++;
            $display("FAIL byte_merge got data=%h err=%b want DE22BE44 0", d, e);
        end
        do_write(14'h0010, 32'hFFFFFFFF, 4'h0);
        do_read(14'h0010, d, e, lat);
        checks++;
        if (d !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL be_zero_noop got data=%h want DE22BE44", d);
        end
    endtask

    task automatic test_back_to_back();
        do_write(14'h0030, 32'h30303030, 4'hF);
        do_write(14'h0031, 32'h31313131, 4'hF);
        do_write(14'h0032, 32'h32323232, 4'hF);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 14'h0030;
        #1;
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_first_ready got %b want 1", req_ready_o);
        end
        tick();
        req_addr_i = 14'h0031;
        #1;
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_second_ready got %b want 1", req_ready_o);
        end
        tick();
        req_addr_i = 14'h0032;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) rsp_ready_i = 1'b1;
            #1;
            checks++;
            if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h30303030) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got ready=%b valid=%b data=%h want 0 1 30303030",
                         c, req_ready_o, rsp_valid_o, rsp_rdata_o);
            end
            tick();
        end
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h31313131) begin
            failures++;
            $display("FAIL bp_second_rsp got ready=%b valid=%b data=%h want 1 1 31313131",
                     req_ready_o, rsp_valid_o, rsp_rdata_o);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL simul_accept_hs got ready=%b valid=%b want 1 0", req_ready_o, rsp_valid_o);
        end
        tick();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h32323232) begin
            failures++;
            $display("FAIL bp_third_rsp got valid=%b data=%h want 1 32323232", rsp_valid_o, rsp_rdata_o);
        end
        tick();
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_drained got valid=%b want 0", rsp_valid_o);
        end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] d;
        logic        e;
        int          lat;
        int          stray;
        do_write(14'h0040, 32'hCAFEF00D, 4'hF);
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 14'h0040;
        #1;
        tick();
        tick();
        rst         = 1'b1;
        req_we_i    = 1'b1;
        req_be_i    = 4'hF;
        req_wdata_i = 32'h0BADBAD0;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_inflight_mask got valid=%b ready=%b want 0 0", rsp_valid_o, req_ready_o);
        end
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (rsp_valid_o !== 1'b0) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL rst_inflight_discard got %0d stray responses want 0", stray);
        end
        do_read(14'h0040, d, e, lat);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL rst_mem_retained got data=%h want CAFEF00D", d);
        end
    endtask

    task automatic test_parity();
        logic [31:0] d;
        logic [31:0] w;
        logic        e;
        logic        exp_err;
        int          lat;
`ifdef SRAM_PARITY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_write(14'h0020, 32'hA5A5A5A5, 4'hF);
        do_read(14'h0020, d, e, lat);
        checks++;
        if (d !== 32'hA5A5A5A5 || e !== 1'b0) begin
            failures++;
            $display("FAIL parity_clean got data=%h err=%b want A5A5A5A5 0", d, e);
        end
        w = dut.mem[14'h0020];
        w[3] = ~w[3];
        dut.mem[14'h0020] = w;
        do_read(14'h0020, d, e, lat);
        checks++;
        if (d !== 32'hA5A5A5AD || e !== exp_err) begin
            failures++;
            $display("FAIL parity_flip got data=%h err=%b want A5A5A5AD %b", d, e, exp_err);
        end
    endtask

    task automatic test_random();
        int  last_hs;
        int  cyc;
        bit  exp_ready;
        bit  exp_valid;
        int  bad;
        int  a;
        logic [31:0] w;
        for (int i = 0; i < 16; i++) do_write(14'h0100 + 14'(i), $urandom, 4'hF);
        exp_q.delete();
        last_hs = -10;
        bad     = 0;
        for (cyc = 0; cyc < 700; cyc++) begin
            if (cyc < 680) begin
                req_valid_i = ($urandom_range(0, 3) != 0);
                req_we_i    = ($urandom_range(0, 2) == 0);
                req_be_i    = 4'($urandom);
                req_addr_i  = 14'h0100 + 14'($urandom_range(0, 15));
                req_wdata_i = $urandom;
                rsp_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                idle_inputs();
                rsp_ready_i = 1'b1;
            end
            #1;
            exp_ready = (exp_q.size() < L);
            exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].t_acc + L) && (cyc >= last_hs + 1);
            checks++;
            if (req_ready_o !== exp_ready || rsp_valid_o !== exp_valid ||
                (exp_valid && (rsp_rdata_o !== exp_q[0].data || rsp_err_o !== 1'b0))) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random cyc=%0d got ready=%b valid=%b data=%h want %b %b %h",
                             cyc, req_ready_o, rsp_valid_o, rsp_rdata_o, exp_ready, exp_valid,
                             (exp_q.size() > 0) ? exp_q[0].data : 32'h0);
            end
            if (exp_valid && rsp_ready_i) begin
                void'(exp_q.pop_front());
                last_hs = cyc;
            end
            if (req_valid_i && exp_ready) begin
                a = int'(req_addr_i);
                if (req_we_i) begin
                    model_mem[a] = merge(model_mem[a], req_wdata_i, req_be_i);
                end else begin
                    w = model_mem[a];
                    exp_q.push_back('{data: w, t_acc: cyc});
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_drain got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready_i = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_reset_inflight();
        test_parity();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_1rw_pipe.md
SRAM_1RW_PIPE -- requirements
Module: sram_1rw_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 14, address width; depth SHALL be 1<<ADDR_WIDTH words.
REQ-003 Parameter READ_LATENCY, default 2, cycles from read accept to earliest response; legal range 1..4.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  1  request present.
REQ-007 req_ready_o  output  1  block can accept a request this cycle.
REQ-008 req_we_i  input  1  1 = write, 0 = read.
REQ-009 req_be_i  input  DATA_WIDTH/8  per-byte write enable; ignored on reads.
REQ-010 req_addr_i  input  ADDR_WIDTH  word address.
REQ-011 req_wdata_i  input  DATA_WIDTH  write data.
REQ-012 rsp_valid_o  output  1  read data available.
REQ-013 rsp_ready_i  input  1  consumer takes response this cycle.
REQ-014 rsp_rdata_o  output  DATA_WIDTH  read data.
REQ-015 rsp_err_o  output  1  parity error on this response (see Configuration).

Function
REQ-016 A request SHALL be accepted in any cycle where req_valid_i && req_ready_o.
REQ-017 An accepted write SHALL update only bytes with req_be_i[k]=1 at the accept edge; req_be_i=0 SHALL be accepted as a no-op write; writes SHALL produce no response.
REQ-018 An accepted read SHALL sample memory at the accept edge, traverse READ_LATENCY pipeline stages, then enter a response FIFO of depth READ_LATENCY.
REQ-019 With FIFO empty and rsp_ready_i=1, read accepted at cycle T SHALL present rsp_valid_o=1 with data in cycle T+READ_LATENCY.
REQ-020 Responses SHALL be returned in request order; rsp_valid_o/rsp_rdata_o/rsp_err_o SHALL stay stable while rsp_valid_o && !rsp_ready_i.
REQ-021 Outstanding counter cnt (reads in pipeline + FIFO) SHALL increment on read accept, decrement on response handshake, hold when both occur in the same cycle.
REQ-022 req_ready_o SHALL equal (cnt < READ_LATENCY) && !rst, driven from registered state only (no combinational path from rsp_ready_i); writes are subject to the same gating.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the written (byte-merged) data.
REQ-024 The FIFO SHALL never overflow; cnt==READ_LATENCY is the full condition, cnt==0 implies rsp_valid_o=0.
REQ-025 Pointers SHALL wrap modulo READ_LATENCY; occupancy SHALL be tracked by count, not pointer compare.

Reset
REQ-026 On rst, cnt, FIFO pointers and pipeline valid bits SHALL clear; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, req_ready_o=0 during reset and 1 the cycle after release.
REQ-027 Memory array contents SHALL NOT be reset; reads in flight at reset SHALL be discarded with no response; a write presented in a reset cycle SHALL NOT be performed.

Configuration
REQ-028 Macro SRAM_PARITY_EN defined: one even-parity bit per byte SHALL be stored on write (only for enabled bytes) and checked on read; rsp_err_o=1 if any byte mismatches, data returned unmodified.
REQ-029 Macro SRAM_PARITY_EN undefined: no parity storage, rsp_err_o SHALL be tied to 0.

Verification
REQ-030 Write addr 0x0010 data 0xDEADBEEF be=0xF, read 0x0010 next cycle -> response 0xDEADBEEF at accept+2 (READ_LATENCY=2), rsp_err_o=0.
REQ-031 Write 0x0010 data 0x11223344 be=0x5 over 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-032 rsp_ready_i=0, issue 3 back-to-back reads (READ_LATENCY=2) -> 2 accepted, req_ready_o=0 on third; raise rsp_ready_i -> responses in order, third then accepted.
REQ-033 Simultaneous read accept and response handshake at cnt=1 -> cnt stays 1, req_ready_o stays 1.
REQ-034 Assert rst with 2 reads in flight -> no rsp_valid_o after reset; memory data written before reset still readable after.
REQ-035 With SRAM_PARITY_EN, force-flip stored bit 3 of word 0x0020 via backdoor, read 0x0020 -> rsp_err_o=1; without macro -> rsp_err_o=0.
